sample_packer: RTL



---
 rtl/sample_packer_pkg.sv | 15 +
 rtl/packer_sync_fifo.sv | 63 ++++++
 rtl/sample_packer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sample_packer_pkg.sv
// Shared types for the sample packer: controller states and sticky error bit positions.
package sample_packer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    localparam int ERR_LATE_WRITE = 0;
    localparam int ERR_OVERFLOW   = 1;
    localparam int NUM_ERRORS     = 2;

endpackage

// File: rtl/packer_sync_fifo.sv
// Single-clock output word FIFO; head word is presented combinationally from storage.
module packer_sync_fifo
    import sample_packer_pkg::*;
#(
    parameter int pWIDTH = 64,
    parameter int pDEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              push,
    input  logic [pWIDTH-1:0] push_data,
    input  logic              pop,
    output logic [pWIDTH-1:0] head_data,
    output logic              full,
    output logic              empty
);
    localparam int PTR_W = $clog2(pDEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(pDEPTH);

    logic [pWIDTH-1:0] mem [pDEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              do_push;
    logic              do_pop;

    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign do_pop    = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < pDEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sample_packer.sv
// Packs full- or narrow-width samples MSB-first into output words and queues them for a consumer.
// state      | meaning
// ST_IDLE    | no capture in progress
// ST_CAPTURE | accepting samples into the accumulator
// ST_FLUSH   | pushing the zero-padded residue (if any)
// ST_DRAIN   | waiting for the consumer to empty the FIFO
module sample_packer
    import sample_packer_pkg::*;
#(
    parameter int pSAMPLE_WIDTH = 18,
    parameter int pNARROW_WIDTH = 8,
    parameter int pOUT_WIDTH    = 64,
    parameter int pDEPTH        = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enabled,
    input  logic                     capture_start,
    input  logic                     capture_done,
    input  logic                     I_narrow_mode,
    input  logic [pSAMPLE_WIDTH-1:0] I_data,
    input  logic                     I_wr,
    output logic                     I_full,
    output logic [pOUT_WIDTH-1:0]    O_data,
    output logic                     O_valid,
    input  logic                     O_ready,
    output logic                     capture_done_out,
    input  logic                     clear_fifo_errors,
    output logic [NUM_ERRORS-1:0]    fifo_errors
);
    localparam int ACC_W = pOUT_WIDTH + pSAMPLE_WIDTH - 1;
    localparam int CNT_W = $clog2(pOUT_WIDTH + pSAMPLE_WIDTH);
    localparam logic [CNT_W-1:0] ACC_W_C    = CNT_W'(ACC_W);
    localparam logic [CNT_W-1:0] OUT_W_C    = CNT_W'(pOUT_WIDTH);
    localparam logic [CNT_W-1:0] SAMPLE_W_C = CNT_W'(pSAMPLE_WIDTH);
    localparam logic [CNT_W-1:0] NARROW_W_C = CNT_W'(pNARROW_WIDTH);

    state_t                state, state_next;
    logic [ACC_W-1:0]      acc, acc_sum, sample_ext;
    logic [CNT_W-1:0]      cnt, cnt_sum, sample_w;
    logic                  narrow_q;
    logic                  start, wr_accept, word_ready, flush_push;
    logic                  fifo_push, fifo_clear, fifo_empty, fifo_full;
    logic                  overflow_set, late_set;
    logic [pOUT_WIDTH-1:0] push_data;

    assign start      = enabled && capture_start;
    assign fifo_clear = !enabled || capture_start;
    assign wr_accept  = enabled && !capture_start && (state == ST_CAPTURE) && I_wr && !fifo_full;
    assign flush_push = enabled && !capture_start && (state == ST_FLUSH) && (cnt != '0) && !fifo_full;
    assign overflow_set = enabled && !capture_start && (state == ST_CAPTURE) && I_wr && fifo_full;
    assign late_set     = enabled && !capture_start && I_wr &&
                          ((state == ST_FLUSH) || (state == ST_DRAIN));

    always_comb begin
        sample_ext = '0;
        if (narrow_q) begin
            sample_ext[pNARROW_WIDTH-1:0] = I_data[pNARROW_WIDTH-1:0];
        end else begin
            sample_ext[pSAMPLE_WIDTH-1:0] = I_data;
        end
    end

    // Valid bits sit left-aligned in the accumulator; a new sample lands just below them.
    assign sample_w   = narrow_q ? NARROW_W_C : SAMPLE_W_C;
    assign acc_sum    = acc | (sample_ext << (ACC_W_C - cnt - sample_w));
    assign cnt_sum    = cnt + sample_w;
    assign word_ready = (cnt_sum >= OUT_W_C);
    assign fifo_push  = (wr_accept && word_ready) || flush_push;
    assign push_data  = flush_push ? acc[ACC_W-1 -: pOUT_WIDTH] : acc_sum[ACC_W-1 -: pOUT_WIDTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc      <= '0;
            cnt      <= '0;
            narrow_q <= 1'b0;
        end else begin
            if (start) begin
                narrow_q <= I_narrow_mode;
            end
            if (fifo_clear || flush_push) begin
                acc <= '0;
                cnt <= '0;
            end else if (wr_accept) begin
                if (word_ready) begin
                    acc <= acc_sum << pOUT_WIDTH;
                    cnt <= cnt_sum - OUT_W_C;
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt_sum;
                end
            end
        end
    end

    // Setting an error outranks clearing it in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_errors <= '0;
        end else if (start) begin
            fifo_errors <= '0;
        end else begin
            if (overflow_set) begin
                fifo_errors[ERR_OVERFLOW] <= 1'b1;
            end else if (clear_fifo_errors) begin
                fifo_errors[ERR_OVERFLOW] <= 1'b0;
            end
            if (late_set) begin
                fifo_errors[ERR_LATE_WRITE] <= 1'b1;
            end else if (clear_fifo_errors) begin
                fifo_errors[ERR_LATE_WRITE] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:    state_next = ST_IDLE;
            ST_CAPTURE: if (capture_done) state_next = ST_FLUSH;
            ST_FLUSH:   if ((cnt == '0) || !fifo_full) state_next = ST_DRAIN;
            ST_DRAIN:   if (fifo_empty) state_next = ST_IDLE;
        endcase
        if (capture_start) begin
            state_next = ST_CAPTURE;
        end
        if (!enabled) begin
            state_next = ST_IDLE;
        end
    end

    always_comb begin
        capture_done_out = (state == ST_DRAIN) && fifo_empty && enabled && !capture_start;
    end

    assign I_full  = fifo_full;
    assign O_valid = !fifo_empty;

    packer_sync_fifo #(
        .pWIDTH (pOUT_WIDTH),
        .pDEPTH (pDEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (fifo_clear),
        .push      (fifo_push),
        .push_data (push_data),
        .pop       (O_valid && O_ready),
        .head_data (O_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
